button_debouncer: RTL
=====================

// Module: button_debouncer
// PURPOSE
//   Conditions the raw push-button inputs of the board (btnC/U/D/L/R) before
//   any control logic uses them. For each button: 2-FF synchronizer, then a
//   stability-counter debouncer. Outputs are a clean debounced level plus
//   one-cycle press and release pulses.
//   Sits directly upstream of the hold-to-reset controller and mode/set logic:
//   btn_level feeds their level inputs, btn_press/btn_release feed edge logic.
// PARAMETERS
//   WIDTH            5          number of independent button channels
//   DEBOUNCE_CYCLES  1_000_000  consecutive stable clk cycles required to accept a
//                               new level (10 ms @ 100 MHz); legal range >= 2
// PORTS
//   clk          in   1      system clock; all state updates on rising edge
//   rst_n        in   1      asynchronous reset, active-low
//   btn_raw      in   WIDTH  raw, asynchronous, bouncing button inputs (1 = pressed)
//   btn_level    out  WIDTH  debounced button level, registered
//   btn_press    out  WIDTH  1-cycle pulse when btn_level goes 0->1, registered
//   btn_release  out  WIDTH  1-cycle pulse when btn_level goes 1->0, registered
// BEHAVIOUR
//   - Reset (rst_n=0): clears every register immediately, without waiting for clk:
//     sync FFs, counters, btn_level, btn_press and btn_release all go to 0.
//     Reset has priority over all other activity, including mid-count.
//   - Per channel i, all channels fully independent, identical logic:
//     sync1[i] <= btn_raw[i]; sync2[i] <= sync1[i]. Only sync2 feeds logic below.
//   - Counter cnt[i] is $clog2(DEBOUNCE_CYCLES) bits wide and never wraps.
//     Each rising edge:
//       * sync2 == btn_level: cnt <= 0.
//       * sync2 != btn_level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//       * sync2 != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= sync2,
//         cnt <= 0, and btn_press (if sync2=1) or btn_release (if sync2=0) <= 1.
//     btn_press and btn_release are otherwise 0 on every edge.
//   - Any return of sync2 to the current btn_level before the count completes
//     resets cnt to 0. A partial count is never carried across a bounce.
//   - Latency: call the edge that first samples the new raw value into sync1
//     edge 1. btn_level and the matching pulse update at edge DEBOUNCE_CYCLES+2,
//     provided the raw value stays stable throughout.
//   - Pulse rules:
//     * btn_press and btn_release are exactly 1 cycle wide.
//     * They are coincident with the first cycle of the new btn_level.
//     * They are mutually exclusive per channel.
//     * Each accepted transition produces exactly one pulse.
//   - Button held through reset deassertion: treated as a fresh 0->1 transition.
//     btn_press fires after the full DEBOUNCE_CYCLES+2 latency.
//   - Pulses on different channels can occur in the same cycle. No arbitration.
// TESTING  (bench overrides DEBOUNCE_CYCLES=4, WIDTH=5)
//   1 Clean press: btn_raw[0] 0->1 and held.
//     -> btn_level[0]=1 and btn_press[0]=1 at edge 6; btn_press[0]=0 at edge 7;
//     no release pulse.
//   2 Bouncy press: btn_raw[0] runs the pattern 1,1,1,0,1,1,0,1 (one value per
//     cycle), then stays 1.
//     -> exactly one btn_press[0] pulse, issued 6 edges after the final 0->1.
//   3 Glitch: btn_raw[2] high for 3 cycles, then low.
//     -> btn_level[2] stays 0; no pulses on any channel.
//   4 Release: from debounced 1, btn_raw[0] 1->0 and held.
//     -> btn_level[0]=0 and one-cycle btn_release[0] at edge 6.
//   5 Independence: btn_raw[1] and btn_raw[3] rise 2 cycles apart.
//     -> btn_press[1] and btn_press[3] fire 2 cycles apart; other channels quiet.
//   6 Reset mid-count: btn_raw[4] held 1; rst_n pulled low at count 2.
//     -> all outputs 0 asynchronously. After rst_n rises with btn_raw[4] still 1,
//     btn_press[4] fires at edge 6 (the first post-reset sampling edge is edge 1).

Source files
------------

// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - button input/output bundle between board pins and the debouncer
interface button_debouncer_if #(
   parameter int WIDTH = 5
);
   logic [WIDTH-1:0] btn_raw;
   logic [WIDTH-1:0] btn_level;
   logic [WIDTH-1:0] btn_press;
   logic [WIDTH-1:0] btn_release;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release
   );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-button 2-FF synchronizer and stability-counter debouncer
// Emits a clean level plus one-cycle press/release pulses for each channel.
module button_debouncer #(
   parameter int WIDTH           = 5,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   button_debouncer_if.slave  bus
);
   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [WIDTH-1:0] sync1_q,   sync1_d;
   logic [WIDTH-1:0] sync2_q,   sync2_d;
   logic [WIDTH-1:0] level_q,   level_d;
   logic [WIDTH-1:0] press_q,   press_d;
   logic [WIDTH-1:0] release_q, release_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   always_comb begin
      sync1_d   = bus.btn_raw;
      sync2_d   = sync1_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         // Any cycle agreeing with the current level discards a partial count.
         cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i]   = sync2_q[i];
               press_d[i]   = sync2_q[i];
               release_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.btn_level   = level_q;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = release_q;
endmodule
